// File: rtl/calc_bist_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_bist_pkg: glyphs, KEY encodings and FSM states for the calculator BIST.
// Rev 1.0
// ----------------------------------------------------------------------------
package calc_bist_pkg;

  // Active-low segment glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam int NUM_OPS = 6;

  localparam logic [2:0] KEY_ADD_AB = 3'b000;
  localparam logic [2:0] KEY_ADD_BA = 3'b100;
  localparam logic [2:0] KEY_SUB_AB = 3'b001;
  localparam logic [2:0] KEY_SUB_BA = 3'b101;
  localparam logic [2:0] KEY_ABS_A  = 3'b010;
  localparam logic [2:0] KEY_ABS_B  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       is_minus;
    logic       is_blank;
    logic       is_e;
    logic [3:0] mag;
  } seg_info_t;

  function automatic logic [2:0] op_key(logic [2:0] op);
    case (op)
      3'd0:    return KEY_ADD_AB;
      3'd1:    return KEY_ADD_BA;
      3'd2:    return KEY_SUB_AB;
      3'd3:    return KEY_SUB_BA;
      3'd4:    return KEY_ABS_A;
      3'd5:    return KEY_ABS_B;
      default: return KEY_ADD_AB;
    endcase
  endfunction

  function automatic logic sign_ok(seg_info_t i, logic neg);
    return i.valid && (neg ? i.is_minus : i.is_blank);
  endfunction

  function automatic logic digit_ok(seg_info_t i, logic [3:0] m);
    return i.valid && !i.is_minus && !i.is_blank && !i.is_e && (i.mag == m);
  endfunction

  function automatic logic [3:0] mag5(logic signed [4:0] x);
    return 4'(x[4] ? -x : x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_bist_seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_decode: active-low glyph to {valid, minus, blank, E, magnitude}.
// Rev 1.0
// ----------------------------------------------------------------------------
module seg7_decode
  import calc_bist_pkg::*;
(
  input  logic [6:0] glyph,
  output seg_info_t  info
);

  always_comb begin
    info       = '0;
    info.valid = 1'b1;
    case (glyph)
      SEG_0:     info.mag = 4'd0;
      SEG_1:     info.mag = 4'd1;
      SEG_2:     info.mag = 4'd2;
      SEG_3:     info.mag = 4'd3;
      SEG_4:     info.mag = 4'd4;
      SEG_5:     info.mag = 4'd5;
      SEG_6:     info.mag = 4'd6;
      SEG_7:     info.mag = 4'd7;
      SEG_8:     info.mag = 4'd8;
      SEG_MINUS: info.is_minus = 1'b1;
      SEG_BLANK: info.is_blank = 1'b1;
      SEG_E:     info.is_e = 1'b1;
      default:   info.valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/calc_bist.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_bist: exhaustive KEY/SW sweep of the 4-bit calculator with HEX checking.
// Rev 1.0 -- define CALC_BIST_FAIL_LOG_EN to capture the first failing vector.
// ----------------------------------------------------------------------------
module calc_bist
  import calc_bist_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [5:0] OP_MASK       = 6'b111111,
  parameter bit         STOP_ON_FAIL  = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        start,
  output logic [2:0]  key_o,
  output logic [7:0]  sw_o,
  input  logic [6:0]  hex7_i,
  input  logic [6:0]  hex6_i,
  input  logic [6:0]  hex5_i,
  input  logic [6:0]  hex4_i,
  input  logic [6:0]  hex3_i,
  input  logic [6:0]  hex2_i,
  input  logic [6:0]  hex0_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] err_count,
  output logic [2:0]  fail_key,
  output logic [7:0]  fail_sw
);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt;
  logic [2:0]        r_op;
  logic [7:0]        r_sw;
  logic [2:0]        w_first_op, w_next_op;
  logic              w_first_found, w_next_found, w_last;
  logic signed [4:0] w_a, w_b, w_res;
  logic              w_ovf, w_mismatch;
  logic              w_launch, w_check, w_apply, w_settle, w_finish, w_advance, w_busy_nxt;
  logic [6:0]        w_glyph [0:6];
  seg_info_t         w_info  [0:6];

  // Decoder slots: 0..5 = hex7..hex2, 6 = hex0
  assign w_glyph[0] = hex7_i;
  assign w_glyph[1] = hex6_i;
  assign w_glyph[2] = hex5_i;
  assign w_glyph[3] = hex4_i;
  assign w_glyph[4] = hex3_i;
  assign w_glyph[5] = hex2_i;
  assign w_glyph[6] = hex0_i;

  for (genvar gi = 0; gi < 7; gi++) begin : g_dec
    seg7_decode u_dec (.glyph(w_glyph[gi]), .info(w_info[gi]));
  end

  // Lowest enabled op overall and lowest enabled op above the current one
  always_comb begin
    w_first_op    = '0;
    w_first_found = 1'b0;
    w_next_op     = '0;
    w_next_found  = 1'b0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (OP_MASK[i]) begin
        w_first_op    = 3'(i);
        w_first_found = 1'b1;
        if (3'(i) > r_op) begin
          w_next_op    = 3'(i);
          w_next_found = 1'b1;
        end
      end
    end
  end

  assign w_last = (r_sw == 8'hFF) && !w_next_found;

  // Golden model evaluated on the vector currently driven to the calculator
  always_comb begin
    w_a = {sw_o[7], sw_o[7:4]};
    w_b = {sw_o[3], sw_o[3:0]};
    case (key_o)
      KEY_ADD_AB, KEY_ADD_BA: w_res = w_a + w_b;
      KEY_SUB_AB:             w_res = w_a - w_b;
      KEY_SUB_BA:             w_res = w_b - w_a;
      KEY_ABS_A:              w_res = w_a[4] ? -w_a : w_a;
      KEY_ABS_B:              w_res = w_b[4] ? -w_b : w_b;
      default:                w_res = '0;
    endcase
    w_ovf      = (w_res > 5'sd7) || (w_res < -5'sd8);
    w_mismatch = !sign_ok(w_info[0], w_a[4]) || !digit_ok(w_info[1], mag5(w_a)) ||
                 !sign_ok(w_info[2], w_b[4]) || !digit_ok(w_info[3], mag5(w_b)) ||
                 (w_ovf ? !(w_info[6].valid && w_info[6].is_e)
                        : !(w_info[6].valid && w_info[6].is_blank)) ||
                 (!w_ovf && (!sign_ok(w_info[4], w_res[4]) ||
                             !digit_ok(w_info[5], mag5(w_res))));
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = w_first_found ? ST_APPLY : ST_DONE;
      ST_APPLY:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cnt == 8'(SETTLE_CYCLES - 1)) w_state_nxt = ST_CHECK;
      ST_CHECK:  begin
        if ((w_mismatch && STOP_ON_FAIL) || w_last) w_state_nxt = ST_DONE;
        else                                        w_state_nxt = ST_APPLY;
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_launch   = (r_state == ST_IDLE) && start;
    w_apply    = (r_state == ST_APPLY);
    w_settle   = (r_state == ST_SETTLE);
    w_check    = (r_state == ST_CHECK);
    w_finish   = (r_state == ST_DONE);
    w_advance  = w_check && (w_state_nxt == ST_APPLY);
    w_busy_nxt = (w_state_nxt == ST_APPLY) || (w_state_nxt == ST_SETTLE) ||
                 (w_state_nxt == ST_CHECK);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      key_o     <= '0;
      sw_o      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_sw      <= '0;
    end else begin
      busy <= w_busy_nxt;
      if (w_launch) begin
        done      <= 1'b0;
        pass      <= 1'b0;
        err_count <= '0;
        r_op      <= w_first_op;
        r_sw      <= '0;
      end
      if (w_apply) begin
        key_o <= op_key(r_op);
        sw_o  <= r_sw;
        r_cnt <= '0;
      end
      if (w_settle) r_cnt <= r_cnt + 8'd1;
      if (w_check && w_mismatch && (err_count != 11'h7FF)) err_count <= err_count + 11'd1;
      if (w_advance) begin
        if (r_sw == 8'hFF) begin
          r_op <= w_next_op;
          r_sw <= '0;
        end else begin
          r_sw <= r_sw + 8'd1;
        end
      end
      if (w_finish) begin
        done <= 1'b1;
        pass <= (err_count == '0);
      end
    end
  end

`ifdef CALC_BIST_FAIL_LOG_EN
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      fail_key <= '0;
      fail_sw  <= '0;
    end else if (w_launch) begin
      fail_key <= '0;
      fail_sw  <= '0;
    end else if (w_check && w_mismatch && (err_count == '0)) begin
      fail_key <= key_o;
      fail_sw  <= sw_o;
    end
  end
`else
  assign fail_key = '0;
  assign fail_sw  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc_bist.sv
`default_nettype none
// tb_calc_bist: drives calc_bist against a behavioural calculator and checks
// every cycle of the main sweep against a vector-level model of the sweep.
module tb_calc_bist;

  localparam int S      = 4;
  localparam int PER    = S + 2;
  localparam int NV     = 1536;
  localparam int T_DONE = NV * PER + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_m = 1'b0, start_s = 1'b0, start_a = 1'b0;
  logic fault = 1'b0;

  logic [2:0] key_m, key_s, key_a;
  logic [7:0] sw_m, sw_s, sw_a;
  logic [48:0] hx_m, hx_s, hx_a;
  logic busy_m, done_m, pass_m, busy_s, done_s, pass_s, busy_a, done_a, pass_a;
  logic [10:0] err_m, err_s, err_a;
  logic [2:0] fk_m, fk_s, fk_a;
  logic [7:0] fs_m, fs_s, fs_a;

  int n_cmp = 0;
  int n_bad = 0;
  int n = -100;
  bit track = 1'b0;
  bit finished = 1'b0;

  int pre [0:NV];
  int first_fail;
  logic [2:0] vkey [0:NV-1];
  logic [7:0] vsw  [0:NV-1];

  // ---------------- behavioural calculator ----------------
  function automatic logic [6:0] seg(int m);
    case (m)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int result(logic [2:0] key, logic [7:0] sw);
    int a, b;
    a = int'($signed(sw[7:4]));
    b = int'($signed(sw[3:0]));
    case (key)
      3'b000, 3'b100: return a + b;
      3'b001:         return a - b;
      3'b101:         return b - a;
      3'b010:         return iabs(a);
      3'b110:         return iabs(b);
      default:        return 0;
    endcase
  endfunction

  function automatic logic [48:0] calc_model(logic [2:0] key, logic [7:0] sw, logic stuck);
    int a, b, r;
    bit ovf;
    logic [6:0] h7, h6, h5, h4, h3, h2, h0;
    a   = int'($signed(sw[7:4]));
    b   = int'($signed(sw[3:0]));
    r   = result(key, sw);
    ovf = (r > 7) || (r < -8);
    h7  = (a < 0) ? 7'b0111111 : 7'b1111111;
    h6  = seg(iabs(a));
    h5  = (b < 0) ? 7'b0111111 : 7'b1111111;
    h4  = seg(iabs(b));
    h3  = (!ovf && r < 0) ? 7'b0111111 : 7'b1111111;
    h2  = ovf ? 7'b1111111 : seg(iabs(r));
    h0  = (ovf && !stuck) ? 7'b0000110 : 7'b1111111;
    return {h7, h6, h5, h4, h3, h2, h0};
  endfunction

  // A vector fails when any checked digit differs from the healthy display
  function automatic bit mism(logic [2:0] key, logic [7:0] sw, logic stuck);
    logic [48:0] got, want, mask;
    int r;
    r    = result(key, sw);
    got  = calc_model(key, sw, stuck);
    want = calc_model(key, sw, 1'b0);
    mask = ((r > 7) || (r < -8)) ? ~(49'h3FFF << 7) : '1;
    return ((got ^ want) & mask) != '0;
  endfunction

  function automatic logic [2:0] keytab(int op);
    case (op)
      0: return 3'b000;
      1: return 3'b100;
      2: return 3'b001;
      3: return 3'b101;
      4: return 3'b010;
      default: return 3'b110;
    endcase
  endfunction

  assign hx_m = calc_model(key_m, sw_m, fault);
  assign hx_s = calc_model(key_s, sw_s, fault);
  assign hx_a = calc_model(key_a, sw_a, fault);

  calc_bist #(.SETTLE_CYCLES(S)) dut_m (
    .CLOCK_50(clk), .RESET(rst), .start(start_m), .key_o(key_m), .sw_o(sw_m),
    .hex7_i(hx_m[48:42]), .hex6_i(hx_m[41:35]), .hex5_i(hx_m[34:28]), .hex4_i(hx_m[27:21]),
    .hex3_i(hx_m[20:14]), .hex2_i(hx_m[13:7]), .hex0_i(hx_m[6:0]),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
    .fail_key(fk_m), .fail_sw(fs_m));

  calc_bist #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b1)) dut_s (
    .CLOCK_50(clk), .RESET(rst), .start(start_s), .key_o(key_s), .sw_o(sw_s),
    .hex7_i(hx_s[48:42]), .hex6_i(hx_s[41:35]), .hex5_i(hx_s[34:28]), .hex4_i(hx_s[27:21]),
    .hex3_i(hx_s[20:14]), .hex2_i(hx_s[13:7]), .hex0_i(hx_s[6:0]),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .fail_key(fk_s), .fail_sw(fs_s));

  calc_bist #(.SETTLE_CYCLES(S), .OP_MASK(6'b010000)) dut_a (
    .CLOCK_50(clk), .RESET(rst), .start(start_a), .key_o(key_a), .sw_o(sw_a),
    .hex7_i(hx_a[48:42]), .hex6_i(hx_a[41:35]), .hex5_i(hx_a[34:28]), .hex4_i(hx_a[27:21]),
    .hex3_i(hx_a[20:14]), .hex2_i(hx_a[13:7]), .hex0_i(hx_a[6:0]),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_key(fk_a), .fail_sw(fs_a));

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic prepare(logic stuck);
    pre[0]     = 0;
    first_fail = -1;
    for (int k = 0; k < NV; k++) begin
      vkey[k] = keytab(k / 256);
      vsw[k]  = 8'(k % 256);
      if (mism(vkey[k], vsw[k], stuck)) begin
        pre[k+1] = pre[k] + 1;
        if (first_fail < 0) first_fail = k;
      end else begin
        pre[k+1] = pre[k];
      end
    end
  endtask

  // n counts rising edges since the edge that sampled start (that edge is n=0)
  always @(posedge clk) n = n + 1;

  task automatic launch_m();
    @(negedge clk);
    n       = -1;
    track   = 1'b1;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
  endtask

  task automatic wait_n(int t);
    while (n < t) @(negedge clk);
  endtask

  // Cycle-by-cycle comparison of the main instance against the sweep model
  always @(negedge clk) begin
    int ci, vi;
    logic [2:0] efk;
    logic [7:0] efs;
    logic [24:0] exp_st, act_st;
    if (track && n >= 0 && n <= T_DONE) begin
      ci  = n / PER;
      if (ci > NV) ci = NV;
      efk = '0;
      efs = '0;
`ifdef CALC_BIST_FAIL_LOG_EN
      if (first_fail >= 0 && n >= (first_fail + 1) * PER) begin
        efk = vkey[first_fail];
        efs = vsw[first_fail];
      end
`endif
      exp_st = {n <= NV * PER - 1, n >= T_DONE, (n >= T_DONE) && (pre[NV] == 0),
                11'(pre[ci]), efk, efs};
      act_st = {busy_m, done_m, pass_m, err_m, fk_m, fs_m};
      check("status", 64'(act_st), 64'(exp_st));
      if (n >= 1) begin
        vi = (n - 1) / PER;
        if (vi > NV - 1) vi = NV - 1;
        check("vector", 64'({key_m, sw_m}), 64'({vkey[vi], vsw[vi]}));
      end
    end
  end

  initial begin
    int cnt, bad_key;
    logic [7:0] exp_fs;

    repeat (3) @(negedge clk);
    check("reset_m", 64'({key_m, sw_m, busy_m, done_m, pass_m, err_m, fk_m, fs_m}), 64'd0);
    check("reset_s", 64'({key_s, sw_s, busy_s, done_s, pass_s, err_s, fk_s, fs_s}), 64'd0);
    check("reset_a", 64'({key_a, sw_a, busy_a, done_a, pass_a, err_a, fk_a, fs_a}), 64'd0);
    rst = 1'b0;

    // Healthy calculator, all ops
    fault = 1'b0;
    prepare(1'b0);
    launch_m();
    wait_n(T_DONE - 1);
    check("ok_not_done_early", 64'(done_m), 64'd0);
    wait_n(T_DONE);
    check("ok_done", 64'(done_m), 64'd1);
    check("ok_pass", 64'(pass_m), 64'd1);
    check("ok_err", 64'(err_m), 64'd0);
    track = 1'b0;

    // Only |A| enabled
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cnt = 0;
    bad_key = 0;
    while (!done_a && cnt < 4000) begin
      @(negedge clk);
      cnt++;
      if (busy_a && key_a != 3'b010) bad_key++;
    end
    check("abs_latency", 64'(cnt), 64'd1537);
    check("abs_key_only", 64'(bad_key), 64'd0);
    check("abs_last_vec", 64'({key_a, sw_a}), 64'({3'b010, 8'hFF}));
    check("abs_pass_err", 64'({pass_a, err_a}), 64'({1'b1, 11'd0}));

    // hex0 stuck blank: every overflowing vector fails
    fault = 1'b1;
    prepare(1'b1);
    launch_m();
    wait_n(T_DONE);
    check("fault_err", 64'(err_m), 64'd288);
    check("fault_pass", 64'({done_m, pass_m}), 64'({1'b1, 1'b0}));
`ifdef CALC_BIST_FAIL_LOG_EN
    exp_fs = 8'h17;
`else
    exp_fs = 8'h00;
`endif
    check("fault_first", 64'({fk_m, fs_m}), 64'({3'b000, exp_fs}));
    track = 1'b0;

    // Stop on first failure (A=1, B=7 -> 8, vector index 23)
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    cnt = 0;
    while (!done_s && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("stop_latency", 64'(cnt), 64'd145);
    check("stop_err", 64'(err_s), 64'd1);
    check("stop_vec", 64'({key_s, sw_s}), 64'({3'b000, 8'h17}));
    check("stop_flags", 64'({busy_s, pass_s}), 64'd0);

    // start pulsed mid-sweep must be ignored
    launch_m();
    wait_n(1000);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_n(T_DONE);
    check("restart_ignored_err", 64'(err_m), 64'd288);
    check("restart_ignored_done", 64'(done_m), 64'd1);
    track = 1'b0;

    // Asynchronous reset in the middle of a sweep
    fault = 1'b0;
    prepare(1'b0);
    launch_m();
    wait_n(499);
    track = 1'b0;
    rst   = 1'b1;
    #1;
    check("midrst_async", 64'({key_m, sw_m, busy_m, done_m, pass_m, err_m, fk_m, fs_m}), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_edge", 64'({key_m, sw_m, busy_m, done_m, pass_m, err_m, fk_m, fs_m}), 64'd0);
    @(negedge clk) rst = 1'b0;
    launch_m();
    @(negedge clk);
    check("after_rst_first_vec", 64'({key_m, sw_m}), 64'd0);
    wait_n(T_DONE);
    check("after_rst_done", 64'({done_m, pass_m, err_m}), 64'({1'b1, 1'b1, 11'd0}));
    track = 1'b0;

    finished = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    if (!finished) begin
      n_bad++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

endmodule
`default_nettype wire
